tl_rx_demux: RTL and testbench

- Receive-side counterpart of the TL transmit arbiter.
- Accepts the TLP stream from the data-link layer, decodes the first header DW, and steers each whole TLP to one of three RX queues: posted, non-posted or completion.
- Drops unsupported TLPs and framing errors.
- After each TLP is forwarded, issues header and data credit-release pulses to tl_credit_mgr.

---
 rtl/tl_rx_demux_if.sv | 25 ++
 rtl/tl_rx_demux.sv | 243 ++++++++++++++++++++++++
 tb/tb_tl_rx_demux.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tl_rx_demux_if.sv
// ----------------------------------------------------------------------------
// tl_rx_demux_if
//   One TLP stream link. It carries a beat (data, sop, eop) with valid/ready
//   flow control.
//
//   Handshake: a beat transfers on a rising clk edge where valid && ready are
//   both high. The master holds data/sop/eop stable and keeps valid high until
//   that transfer happens. Ready may depend on valid and on the decoded beat.
//   Valid never depends on ready.
//
//   master : drives data, sop, eop, valid; samples ready
//   slave  : samples data, sop, eop, valid; drives ready
// ----------------------------------------------------------------------------
interface tl_rx_demux_if #(
    parameter int STREAM_W = 128
);
    logic [STREAM_W-1:0] data;
    logic                sop;
    logic                eop;
    logic                valid;
    logic                ready;

    modport master (output data, sop, eop, valid, input ready);
    modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/tl_rx_demux.sv
// ----------------------------------------------------------------------------
// tl_rx_demux
//   Receive-side TLP demultiplexer. It takes the TLP stream from the data-link
//   layer and decodes header DW0 on the SOP beat. It then steers every beat of
//   the TLP to the posted, non-posted or completion queue.
//   Unsupported TLPs are dropped. Beats that break framing are flagged.
//   When a forwarded TLP closes, the block issues one-cycle credit-release
//   pulses.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   tl_rx               input beat stream from the DLL (slave side)
//   pkt_posted/np/cpl   registered output queues (master side), 1-cycle latency
//   *h_release_v/dw_o   header credit release, dw = number of headers freed
//   *d_release_v/dw_o   data credit release in DW (only for TLPs with data)
//   unsup_tlp_o         pulse: unsupported TLP dropped
//   malformed_o         pulse: orphan beat in IDLE, or SOP inside a TLP
//   dbg_state_o         FSM state (0 IDLE, 1 FWD, 2 DROP)
// ----------------------------------------------------------------------------
module tl_rx_demux #(
    parameter int STREAM_W   = 128,
    parameter int PH_WIDTH   = 8,
    parameter int PD_WIDTH   = 12,
    parameter int NPH_WIDTH  = 8,
    parameter int NPD_WIDTH  = 12,
    parameter int CPLH_WIDTH = 8,
    parameter int CPLD_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tl_rx_demux_if.slave          tl_rx,
    tl_rx_demux_if.master         pkt_posted,
    tl_rx_demux_if.master         pkt_np,
    tl_rx_demux_if.master         pkt_cpl,
    output logic                  ph_release_v_o,
    output logic [PH_WIDTH-1:0]   ph_release_dw_o,
    output logic                  pd_release_v_o,
    output logic [PD_WIDTH-1:0]   pd_release_dw_o,
    output logic                  nph_release_v_o,
    output logic [NPH_WIDTH-1:0]  nph_release_dw_o,
    output logic                  npd_release_v_o,
    output logic [NPD_WIDTH-1:0]  npd_release_dw_o,
    output logic                  cplh_release_v_o,
    output logic [CPLH_WIDTH-1:0] cplh_release_dw_o,
    output logic                  cpld_release_v_o,
    output logic [CPLD_WIDTH-1:0] cpld_release_dw_o,
    output logic                  unsup_tlp_o,
    output logic                  malformed_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_e;
    // The class value doubles as the output stage index; UNSUP maps to a
    // phantom stage that is always free.
    typedef enum logic [1:0] {CLS_P = 2'd0, CLS_NP = 2'd1, CLS_CPL = 2'd2, CLS_UNSUP = 2'd3} cls_e;

    state_e      state_q, state_d;
    cls_e        cls_q, dec_cls;
    logic        has_q, dec_has;
    logic [10:0] len_q, dec_len;
    logic [9:0]  dec_len_raw;
    logic [4:0]  dec_type;

    // ---------------- header DW0 decode ----------------
    always_comb begin
        dec_has     = tl_rx.data[6];
        dec_type    = tl_rx.data[4:0];
        dec_len_raw = {tl_rx.data[17:16], tl_rx.data[31:24]};
        dec_len     = (dec_len_raw == 10'd0) ? 11'd1024 : {1'b0, dec_len_raw};
        dec_cls     = CLS_UNSUP;
        if (dec_type[4:3] == 2'b10) begin
            dec_cls = CLS_P;                              // Msg / MsgD
        end else begin
            case (dec_type)
                5'b00000, 5'b00001:           dec_cls = dec_has ? CLS_P : CLS_NP;  // MWr / MRd
                5'b00010, 5'b00100, 5'b00101: dec_cls = CLS_NP;                    // IO, Cfg
                5'b01010, 5'b01011:           dec_cls = CLS_CPL;
                default:                      dec_cls = CLS_UNSUP;
            endcase
        end
    end

    // ---------------- output stage status ----------------
    logic [2:0]          stg_vld_q, stg_sop_q, stg_eop_q, stg_rdy, stg_load;
    logic [STREAM_W-1:0] stg_data_q [3];
    logic [3:0]          stg_free;
    logic                rx_ready, rx_acc;

    assign stg_rdy  = {pkt_cpl.ready, pkt_np.ready, pkt_posted.ready};
    assign stg_free = {1'b1, ~stg_vld_q | stg_rdy};

    // An SOP beat picks its stage from the decoded class, even inside FWD,
    // because that beat starts a new TLP.
    always_comb begin
        rx_ready = 1'b1;
        case (state_q)
            IDLE: begin
                if (!tl_rx.valid)   rx_ready = stg_free[CLS_P];
                else if (tl_rx.sop) rx_ready = stg_free[dec_cls];
            end
            FWD:     rx_ready = (tl_rx.valid && tl_rx.sop) ? stg_free[dec_cls] : stg_free[cls_q];
            default: rx_ready = 1'b1;
        endcase
    end

    assign tl_rx.ready = rx_ready;
    assign rx_acc      = tl_rx.valid && rx_ready;

    // ---------------- FSM next state ----------------
    logic take_new, rel_old, fwd_old, orphan, new_fwd, rel_new;

    always_comb begin
        state_d  = state_q;
        take_new = 1'b0;
        rel_old  = 1'b0;
        fwd_old  = 1'b0;
        orphan   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_acc) begin
                    if (tl_rx.sop) take_new = 1'b1;
                    else           orphan   = 1'b1;
                end
            end
            FWD: begin
                if (rx_acc) begin
                    if (tl_rx.sop) begin
                        take_new = 1'b1;                  // cut current TLP short
                        rel_old  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        fwd_old = 1'b1;
                        if (tl_rx.eop) begin
                            rel_old = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (rx_acc && tl_rx.eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take_new) begin
            if (dec_cls == CLS_UNSUP) state_d = tl_rx.eop ? IDLE : DROP;
            else                      state_d = tl_rx.eop ? IDLE : FWD;
        end
    end

    assign new_fwd = take_new && (dec_cls != CLS_UNSUP);
    assign rel_new = new_fwd && tl_rx.eop;

    // ---------------- stage load and release amounts ----------------
    // A cut-short TLP and a single-beat TLP that follows it can close in the
    // same cycle. If both are the same class, the two releases are summed.
    logic [1:0]  hcnt [3];
    logic [11:0] dcnt [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stg_load[i] = (fwd_old && cls_q == cls_e'(i)) || (new_fwd && dec_cls == cls_e'(i));
            hcnt[i] = {1'b0, rel_old && cls_q == cls_e'(i)} + {1'b0, rel_new && dec_cls == cls_e'(i)};
            dcnt[i] = ((rel_old && has_q && cls_q == cls_e'(i)) ? {1'b0, len_q} : 12'd0)
                    + ((rel_new && dec_has && dec_cls == cls_e'(i)) ? {1'b0, dec_len} : 12'd0);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cls_q             <= CLS_P;
            has_q             <= 1'b0;
            len_q             <= '0;
            stg_vld_q         <= '0;
            stg_sop_q         <= '0;
            stg_eop_q         <= '0;
            for (int i = 0; i < 3; i++) stg_data_q[i] <= '0;
            ph_release_v_o    <= 1'b0;
            ph_release_dw_o   <= '0;
            pd_release_v_o    <= 1'b0;
            pd_release_dw_o   <= '0;
            nph_release_v_o   <= 1'b0;
            nph_release_dw_o  <= '0;
            npd_release_v_o   <= 1'b0;
            npd_release_dw_o  <= '0;
            cplh_release_v_o  <= 1'b0;
            cplh_release_dw_o <= '0;
            cpld_release_v_o  <= 1'b0;
            cpld_release_dw_o <= '0;
            unsup_tlp_o       <= 1'b0;
            malformed_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (new_fwd) begin
                cls_q <= dec_cls;
                has_q <= dec_has;
                len_q <= dec_len;
            end
            for (int i = 0; i < 3; i++) begin
                if (stg_load[i]) begin
                    stg_vld_q[i]  <= 1'b1;
                    stg_data_q[i] <= tl_rx.data;
                    stg_sop_q[i]  <= tl_rx.sop;
                    stg_eop_q[i]  <= tl_rx.eop;
                end else if (stg_rdy[i]) begin
                    stg_vld_q[i]  <= 1'b0;
                end
            end
            ph_release_v_o    <= (hcnt[0] != 2'd0);
            ph_release_dw_o   <= PH_WIDTH'(hcnt[0]);
            pd_release_v_o    <= (dcnt[0] != 12'd0);
            pd_release_dw_o   <= PD_WIDTH'(dcnt[0]);
            nph_release_v_o   <= (hcnt[1] != 2'd0);
            nph_release_dw_o  <= NPH_WIDTH'(hcnt[1]);
            npd_release_v_o   <= (dcnt[1] != 12'd0);
            npd_release_dw_o  <= NPD_WIDTH'(dcnt[1]);
            cplh_release_v_o  <= (hcnt[2] != 2'd0);
            cplh_release_dw_o <= CPLH_WIDTH'(hcnt[2]);
            cpld_release_v_o  <= (dcnt[2] != 12'd0);
            cpld_release_dw_o <= CPLD_WIDTH'(dcnt[2]);
            unsup_tlp_o       <= take_new && (dec_cls == CLS_UNSUP);
            malformed_o       <= orphan || (take_new && state_q == FWD);
        end
    end

    // ---------------- outputs ----------------
    assign pkt_posted.valid = stg_vld_q[0];
    assign pkt_posted.data  = stg_data_q[0];
    assign pkt_posted.sop   = stg_sop_q[0];
    assign pkt_posted.eop   = stg_eop_q[0];
    assign pkt_np.valid     = stg_vld_q[1];
    assign pkt_np.data      = stg_data_q[1];
    assign pkt_np.sop       = stg_sop_q[1];
    assign pkt_np.eop       = stg_eop_q[1];
    assign pkt_cpl.valid    = stg_vld_q[2];
    assign pkt_cpl.data     = stg_data_q[2];
    assign pkt_cpl.sop      = stg_sop_q[2];
    assign pkt_cpl.eop      = stg_eop_q[2];
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_tl_rx_demux.sv
module tb_tl_rx_demux;

  logic clk;
  logic rst_n;

  tl_rx_demux_if #(.STREAM_W(128)) rx_if ();
  tl_rx_demux_if #(.STREAM_W(128)) p_if ();
  tl_rx_demux_if #(.STREAM_W(128)) np_if ();
  tl_rx_demux_if #(.STREAM_W(128)) cpl_if ();

  logic        ph_v, pd_v, nph_v, npd_v, cplh_v, cpld_v;
  logic [7:0]  ph_dw, nph_dw, cplh_dw;
  logic [11:0] pd_dw, npd_dw, cpld_dw;
  logic        unsup, malf;
  logic [1:0]  dbg_state;

  tl_rx_demux dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tl_rx             (rx_if),
    .pkt_posted        (p_if),
    .pkt_np            (np_if),
    .pkt_cpl           (cpl_if),
    .ph_release_v_o    (ph_v),
    .ph_release_dw_o   (ph_dw),
    .pd_release_v_o    (pd_v),
    .pd_release_dw_o   (pd_dw),
    .nph_release_v_o   (nph_v),
    .nph_release_dw_o  (nph_dw),
    .npd_release_v_o   (npd_v),
    .npd_release_dw_o  (npd_dw),
    .cplh_release_v_o  (cplh_v),
    .cplh_release_dw_o (cplh_dw),
    .cpld_release_v_o  (cpld_v),
    .cpld_release_dw_o (cpld_dw),
    .unsup_tlp_o       (unsup),
    .malformed_o       (malf),
    .dbg_state_o       (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // e_vld = {cpl, np, posted}; e_relv = {ph, pd, nph, npd, cplh, cpld};
  // e_err = {malformed, unsup}; dq = queue whose data is checked (-1 none)
  typedef struct {
    string        name;
    logic         v, s, e;
    logic [127:0] d;
    logic [2:0]   rdy;
    logic         e_rdy;
    logic [2:0]   e_vld;
    logic [5:0]   e_relv;
    logic [11:0]  e_pd, e_npd, e_cpld;
    logic [1:0]   e_err;
    int           dq;
    logic [127:0] e_data;
  } vec_t;

  vec_t vt[$];

  function automatic logic [127:0] hdr(input logic has, input logic [4:0] typ,
                                       input logic [9:0] len, input logic [31:0] tag);
    logic [127:0] d;
    d          = '0;
    d[127:96]  = tag;
    d[6]       = has;
    d[4:0]     = typ;
    d[31:24]   = len[7:0];
    d[17:16]   = len[9:8];
    return d;
  endfunction

  function automatic logic [127:0] pay(input logic [31:0] tag);
    return {tag, 64'h0123_4567_89ab_cdef, 32'h5555_0000};
  endfunction

  function automatic vec_t mk(input string nm, input logic v, input logic s, input logic e,
                              input logic [127:0] d, input logic [2:0] rdy, input logic e_rdy,
                              input logic [2:0] e_vld, input logic [5:0] e_relv,
                              input logic [11:0] e_pd, input logic [11:0] e_npd,
                              input logic [11:0] e_cpld, input logic [1:0] e_err,
                              input int dq, input logic [127:0] e_data);
    vec_t t;
    t.name = nm; t.v = v; t.s = s; t.e = e; t.d = d; t.rdy = rdy; t.e_rdy = e_rdy;
    t.e_vld = e_vld; t.e_relv = e_relv; t.e_pd = e_pd; t.e_npd = e_npd; t.e_cpld = e_cpld;
    t.e_err = e_err; t.dq = dq; t.e_data = e_data;
    return t;
  endfunction

  function automatic logic [127:0] qdata(input int q);
    case (q)
      0:       return p_if.data;
      1:       return np_if.data;
      default: return cpl_if.data;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic s, input logic e, input logic [127:0] d,
                       input logic [2:0] rdy);
    rx_if.valid  = v;
    rx_if.sop    = s;
    rx_if.eop    = e;
    rx_if.data   = d;
    p_if.ready   = rdy[0];
    np_if.ready  = rdy[1];
    cpl_if.ready = rdy[2];
  endtask

  task automatic check_outputs(input string nm, input logic [2:0] e_vld, input logic [5:0] e_relv,
                               input logic [11:0] e_pd, input logic [11:0] e_npd,
                               input logic [11:0] e_cpld, input logic [1:0] e_err);
    chk({nm, ".vld"},  {125'd0, cpl_if.valid, np_if.valid, p_if.valid}, {125'd0, e_vld});
    chk({nm, ".relv"}, {122'd0, ph_v, pd_v, nph_v, npd_v, cplh_v, cpld_v}, {122'd0, e_relv});
    chk({nm, ".hdw"},  {104'd0, ph_dw, nph_dw, cplh_dw},
        {104'd0, 7'd0, e_relv[5], 7'd0, e_relv[3], 7'd0, e_relv[1]});
    chk({nm, ".ddw"},  {92'd0, pd_dw, npd_dw, cpld_dw}, {92'd0, e_pd, e_npd, e_cpld});
    chk({nm, ".err"},  {126'd0, malf, unsup}, {126'd0, e_err});
  endtask

  // Drive at a falling edge, check ready mid-cycle, then check registered
  // results at the next falling edge.
  task automatic apply(input vec_t t);
    drive(t.v, t.s, t.e, t.d, t.rdy);
    #1;
    chk({t.name, ".ready"}, {127'd0, rx_if.ready}, {127'd0, t.e_rdy});
    @(negedge clk);
    check_outputs(t.name, t.e_vld, t.e_relv, t.e_pd, t.e_npd, t.e_cpld, t.e_err);
    if (t.dq >= 0) chk({t.name, ".data"}, qdata(t.dq), t.e_data);
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 3'b111);

    // Posted MWr32 len 4, two beats
    vt.push_back(mk("mwr_sop", 1,1,0, hdr(1,5'h00,10'd4,32'hA1), 3'b111, 1, 3'b001, 6'b000000, 0,0,0, 2'b00, 0, hdr(1,5'h00,10'd4,32'hA1)));
    vt.push_back(mk("mwr_eop", 1,0,1, pay(32'hA2), 3'b111, 1, 3'b001, 6'b110000, 4,0,0, 2'b00, 0, pay(32'hA2)));
    vt.push_back(mk("gap_a",   0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    // MRd len 16, single beat
    vt.push_back(mk("mrd_1b",  1,1,1, hdr(0,5'h00,10'd16,32'hB1), 3'b111, 1, 3'b010, 6'b001000, 0,0,0, 2'b00, 1, hdr(0,5'h00,10'd16,32'hB1)));
    vt.push_back(mk("gap_b",   0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    // Posted stage stalled: idle ready follows posted, NP still flows
    vt.push_back(mk("pst_load",  1,1,1, hdr(1,5'h00,10'd1,32'hB5), 3'b110, 1, 3'b001, 6'b110000, 1,0,0, 2'b00, 0, hdr(1,5'h00,10'd1,32'hB5)));
    vt.push_back(mk("idle_blk",  0,0,0, '0, 3'b110, 0, 3'b001, 6'b000000, 0,0,0, 2'b00, 0, hdr(1,5'h00,10'd1,32'hB5)));
    vt.push_back(mk("np_bypass", 1,1,1, hdr(0,5'h00,10'd2,32'hB7), 3'b110, 1, 3'b011, 6'b001000, 0,0,0, 2'b00, 1, hdr(0,5'h00,10'd2,32'hB7)));
    vt.push_back(mk("drain",     0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    // CplD len 0 (1024 DW) with completion queue stalled 5 cycles
    vt.push_back(mk("cpld_sop", 1,1,0, hdr(1,5'h0A,10'd0,32'hC1), 3'b011, 1, 3'b100, 6'b000000, 0,0,0, 2'b00, 2, hdr(1,5'h0A,10'd0,32'hC1)));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk($sformatf("cpl_stall%0d", i), 1,0,1, pay(32'hC2), 3'b011, 0, 3'b100, 6'b000000, 0,0,0, 2'b00, 2, hdr(1,5'h0A,10'd0,32'hC1)));
    vt.push_back(mk("cpld_eop", 1,0,1, pay(32'hC2), 3'b111, 1, 3'b100, 6'b000011, 0,0,1024, 2'b00, 2, pay(32'hC2)));
    vt.push_back(mk("gap_c",    0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    // Unsupported type 11111, three beats, then a normal MWr
    vt.push_back(mk("unsup_sop", 1,1,0, hdr(1,5'h1F,10'd2,32'hD1), 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b01, -1, '0));
    vt.push_back(mk("unsup_mid", 1,0,0, pay(32'hD2), 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    vt.push_back(mk("unsup_eop", 1,0,1, pay(32'hD3), 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    vt.push_back(mk("mwr_after", 1,1,1, hdr(1,5'h00,10'd1,32'hD4), 3'b111, 1, 3'b001, 6'b110000, 1,0,0, 2'b00, 0, hdr(1,5'h00,10'd1,32'hD4)));
    vt.push_back(mk("gap_d",     0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    // Orphan beat in IDLE, then SOP cutting a posted TLP short
    vt.push_back(mk("orphan",    1,0,0, pay(32'hE1), 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b10, -1, '0));
    vt.push_back(mk("mwr_open",  1,1,0, hdr(1,5'h00,10'd8,32'hE2), 3'b111, 1, 3'b001, 6'b000000, 0,0,0, 2'b00, 0, hdr(1,5'h00,10'd8,32'hE2)));
    vt.push_back(mk("mwr_mid",   1,0,0, pay(32'hE3), 3'b111, 1, 3'b001, 6'b000000, 0,0,0, 2'b00, 0, pay(32'hE3)));
    vt.push_back(mk("cfgrd_cut", 1,1,1, hdr(0,5'h04,10'd1,32'hE4), 3'b111, 1, 3'b010, 6'b111000, 8,0,0, 2'b10, 1, hdr(0,5'h04,10'd1,32'hE4)));
    vt.push_back(mk("gap_e",     0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));
    // Other classes, single beat each, back to back
    vt.push_back(mk("iowr",    1,1,1, hdr(1,5'h02,10'd1,32'hF1), 3'b111, 1, 3'b010, 6'b001100, 0,1,0, 2'b00, 1, hdr(1,5'h02,10'd1,32'hF1)));
    vt.push_back(mk("msg",     1,1,1, hdr(0,5'h14,10'd0,32'hF2), 3'b111, 1, 3'b001, 6'b100000, 0,0,0, 2'b00, 0, hdr(0,5'h14,10'd0,32'hF2)));
    vt.push_back(mk("cpl_nd",  1,1,1, hdr(0,5'h0A,10'd3,32'hF3), 3'b111, 1, 3'b100, 6'b000010, 0,0,0, 2'b00, 2, hdr(0,5'h0A,10'd3,32'hF3)));
    vt.push_back(mk("mwr64",   1,1,1, hdr(1,5'h01,10'h3FF,32'hF4), 3'b111, 1, 3'b001, 6'b110000, 1023,0,0, 2'b00, 0, hdr(1,5'h01,10'h3FF,32'hF4)));
    // Back-to-back multi-beat then single-beat TLP
    vt.push_back(mk("b2b_sop", 1,1,0, hdr(1,5'h00,10'd2,32'h61), 3'b111, 1, 3'b001, 6'b000000, 0,0,0, 2'b00, 0, hdr(1,5'h00,10'd2,32'h61)));
    vt.push_back(mk("b2b_eop", 1,0,1, pay(32'h62), 3'b111, 1, 3'b001, 6'b110000, 2,0,0, 2'b00, 0, pay(32'h62)));
    vt.push_back(mk("b2b_nxt", 1,1,1, hdr(0,5'h00,10'd5,32'h63), 3'b111, 1, 3'b010, 6'b001000, 0,0,0, 2'b00, 1, hdr(0,5'h00,10'd5,32'h63)));
    vt.push_back(mk("gap_g",   0,0,0, '0, 3'b111, 1, 3'b000, 6'b000000, 0,0,0, 2'b00, -1, '0));

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs("reset", 3'b000, 6'b000000, 0, 0, 0, 2'b00);
    chk("reset.state", {126'd0, dbg_state}, 128'd0);
    rst_n = 1'b1;

    foreach (vt[i]) apply(vt[i]);

    // Reset in the middle of a posted TLP
    drive(1'b1, 1'b1, 1'b0, hdr(1,5'h00,10'd4,32'h71), 3'b111);
    @(negedge clk);
    chk("rst_mid.open_vld", {127'd0, p_if.valid}, 128'd1);
    chk("rst_mid.open_state", {126'd0, dbg_state}, 128'd1);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, pay(32'h72), 3'b111);
    @(negedge clk);
    check_outputs("rst_mid", 3'b000, 6'b000000, 0, 0, 0, 2'b00);
    chk("rst_mid.state", {126'd0, dbg_state}, 128'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, hdr(1,5'h00,10'd3,32'h73), 3'b111);
    @(negedge clk);
    check_outputs("rst_after", 3'b001, 6'b110000, 3, 0, 0, 2'b00);
    chk("rst_after.data", p_if.data, hdr(1,5'h00,10'd3,32'h73));
    chk("rst_after.state", {126'd0, dbg_state}, 128'd0);
    drive(1'b0, 1'b0, 1'b0, '0, 3'b111);
    @(negedge clk);
    check_outputs("rst_idle", 3'b000, 6'b000000, 0, 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
